// File: rtl/ristretto_prefetch_buffer.sv
// Prefetch buffer between ristretto_fetch_unit and the IF decoder: owns the fetch PC, queues returned words.
// Optional macro RISTRETTO_PFB_BYPASS_EN adds a 0-cycle path from a returning word to the empty-FIFO head.
module ristretto_prefetch_buffer #(
   parameter int unsigned          DataWidth = 32,
   parameter int unsigned          Depth     = 4,
   parameter logic [DataWidth-1:0] BootPc    = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   output logic                       pfb_fu_fetch_en_o,
   output logic [DataWidth-1:0]       pfb_fu_addr_o,
   input  logic                       pfb_fu_busy_i,
   input  logic                       pfb_fu_new_instr_i,
   input  logic [DataWidth-1:0]       pfb_fu_instr_i,
   input  logic                       pfb_flush_i,
   input  logic [DataWidth-1:0]       pfb_redirect_pc_i,
   output logic                       pfb_instr_valid_o,
   output logic [DataWidth-1:0]       pfb_instr_o,
   output logic [DataWidth-1:0]       pfb_pc_o,
   input  logic                       pfb_instr_ready_i,
   output logic [$clog2(Depth):0]     pfb_count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {
      PFB_IDLE    = 2'd0,
      PFB_WAIT    = 2'd1,
      PFB_DISCARD = 2'd2
   } pfb_state_e;

   pfb_state_e           state_q, state_d;
   logic [DataWidth-1:0] fetch_pc_q, fetch_pc_d;
   logic [DataWidth-1:0] req_pc_q;
   logic [DataWidth-1:0] mem_instr_q [Depth];
   logic [DataWidth-1:0] mem_pc_q    [Depth];
   logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]      count_q;

   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 fetch_en;
   logic                 ret_accept;
   logic                 push;
   logic                 pop;
   logic [DataWidth-1:0] head_instr;
   logic [DataWidth-1:0] head_pc;
   logic [DataWidth-1:0] redirect_aligned;
   logic                 unused_redirect_lsbs;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CntW'(Depth));
   assign head_instr = mem_instr_q[rd_ptr_q];
   assign head_pc    = mem_pc_q[rd_ptr_q];

   // Redirect targets are word aligned; the two low bits are dropped on purpose.
   assign redirect_aligned     = {pfb_redirect_pc_i[DataWidth-1:2], 2'b00};
   assign unused_redirect_lsbs = ^pfb_redirect_pc_i[1:0];

   // Only one fetch may be outstanding, so a request is issued only from IDLE with room left.
   assign fetch_en   = ~rst_i & (state_q == PFB_IDLE) & ~pfb_fu_busy_i & ~pfb_flush_i & ~fifo_full;
   assign ret_accept = (state_q == PFB_WAIT) & pfb_fu_new_instr_i & ~pfb_flush_i;
   assign pop        = ~fifo_empty & pfb_instr_ready_i & ~pfb_flush_i;

`ifdef RISTRETTO_PFB_BYPASS_EN
   logic bypass_hit;

   // A returning word seen by an empty FIFO is presented immediately; it is only stored if not taken.
   assign bypass_hit        = ret_accept & fifo_empty;
   assign push              = ret_accept & ~(bypass_hit & pfb_instr_ready_i);
   assign pfb_instr_valid_o = ~fifo_empty | bypass_hit;
   assign pfb_instr_o       = ~fifo_empty ? head_instr :
                              (bypass_hit ? pfb_fu_instr_i : '0);
   assign pfb_pc_o          = ~fifo_empty ? head_pc :
                              (bypass_hit ? req_pc_q : '0);
`else
   assign push              = ret_accept;
   assign pfb_instr_valid_o = ~fifo_empty;
   assign pfb_instr_o       = fifo_empty ? '0 : head_instr;
   assign pfb_pc_o          = fifo_empty ? '0 : head_pc;
`endif

   assign pfb_fu_fetch_en_o = fetch_en;
   assign pfb_fu_addr_o     = fetch_pc_q;
   assign pfb_count_o       = count_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;

      unique case (state_q)
         PFB_IDLE: begin
            if (fetch_en) begin
               state_d = PFB_WAIT;
            end
         end
         PFB_WAIT: begin
            if (pfb_flush_i) begin
               state_d = pfb_fu_new_instr_i ? PFB_IDLE : PFB_DISCARD;
            end else if (pfb_fu_new_instr_i) begin
               state_d = PFB_IDLE;
            end
         end
         PFB_DISCARD: begin
            if (pfb_fu_new_instr_i) begin
               state_d = PFB_IDLE;
            end
         end
         default: state_d = PFB_IDLE;
      endcase

      // Flush wins over the sequential advance of a same-cycle return.
      if (pfb_flush_i) begin
         fetch_pc_d = redirect_aligned;
      end else if (ret_accept) begin
         fetch_pc_d = fetch_pc_q + DataWidth'(4);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= PFB_IDLE;
         fetch_pc_q <= BootPc;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         if (pfb_flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) begin
               wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
               2'b10:   count_q <= count_q + CntW'(1);
               2'b01:   count_q <= count_q - CntW'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // Datapath storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk_i) begin
      if (fetch_en) begin
         req_pc_q <= fetch_pc_q;
      end
      if (push) begin
         mem_instr_q[wr_ptr_q] <= pfb_fu_instr_i;
         mem_pc_q[wr_ptr_q]    <= req_pc_q;
      end
   end

endmodule

// File: tb/tb_ristretto_prefetch_buffer.sv
// Scoreboard bench for ristretto_prefetch_buffer: directed fetch-unit returns, monitor checks every pop.
module tb_ristretto_prefetch_buffer;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fetch_en;
   logic [DW-1:0] addr;
   logic          busy = 1'b0;
   logic          new_instr = 1'b0;
   logic [DW-1:0] instr = '0;
   logic          flush = 1'b0;
   logic [DW-1:0] redirect = '0;
   logic          valid;
   logic [DW-1:0] instr_o;
   logic [DW-1:0] pc_o;
   logic          ready = 1'b0;
   logic [$clog2(DEPTH):0] count;

   int checks   = 0;
   int failures = 0;
   logic [DW-1:0] exp_pc_q[$];
   logic [DW-1:0] exp_instr_q[$];

   always #5 clk = ~clk;

   ristretto_prefetch_buffer #(
      .DataWidth (DW),
      .Depth     (DEPTH),
      .BootPc    (32'h0000_0100)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .pfb_fu_fetch_en_o  (fetch_en),
      .pfb_fu_addr_o      (addr),
      .pfb_fu_busy_i      (busy),
      .pfb_fu_new_instr_i (new_instr),
      .pfb_fu_instr_i     (instr),
      .pfb_flush_i        (flush),
      .pfb_redirect_pc_i  (redirect),
      .pfb_instr_valid_o  (valid),
      .pfb_instr_o        (instr_o),
      .pfb_pc_o           (pc_o),
      .pfb_instr_ready_i  (ready),
      .pfb_count_o        (count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: every accepted head entry must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && valid === 1'b1 && ready && !flush) begin
         if (exp_pc_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected actual_pc=%h actual_instr=%h required=none", pc_o, instr_o);
         end else begin
            chk("pop_pc", pc_o, exp_pc_q.pop_front());
            chk("pop_instr", instr_o, exp_instr_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pop(input logic [31:0] pc, input logic [31:0] w);
      exp_pc_q.push_back(pc);
      exp_instr_q.push_back(w);
   endtask

   task automatic wait_req(input logic [31:0] exp_addr, input string nm);
      int n;
      n = 0;
      busy = 1'b0;
      @(negedge clk);
      while (fetch_en !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_fetch_en"}, 32'(fetch_en), 32'd1);
      chk({nm, "_addr"}, addr, exp_addr);
      tick();
      busy = 1'b1;
   endtask

   task automatic give_word(input logic [31:0] w);
      new_instr = 1'b1;
      instr     = w;
      tick();
      new_instr = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (count != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(count), 32'd0);
      tick();
   endtask

   initial begin
      int n_en;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_fetch_en", 32'(fetch_en), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_addr", addr, 32'h0000_0100);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("boot_fetch_en", 32'(fetch_en), 32'd1);
      chk("boot_addr", addr, 32'h0000_0100);
      chk("boot_valid", 32'(valid), 32'd0);
      tick();
      busy = 1'b1;

      // Sequential fetch with immediate consumption
      ready = 1'b1;
      expect_pop(32'h100, 32'h0000_0013);
      give_word(32'h0000_0013);
      wait_req(32'h104, "seq1");
      expect_pop(32'h104, 32'h0050_0093);
      give_word(32'h0050_0093);
      wait_req(32'h108, "seq2");
      expect_pop(32'h108, 32'h00A0_0113);
      give_word(32'h00A0_0113);
      drain("seq_drain_count");

      // Fill to Depth with no consumer
      ready = 1'b0;
      wait_req(32'h10C, "fill0");
      expect_pop(32'h10C, 32'hA000_0000);
      give_word(32'hA000_0000);
      wait_req(32'h110, "fill1");
      expect_pop(32'h110, 32'hA000_0001);
      give_word(32'hA000_0001);
      wait_req(32'h114, "fill2");
      expect_pop(32'h114, 32'hA000_0002);
      give_word(32'hA000_0002);
      wait_req(32'h118, "fill3");
      expect_pop(32'h118, 32'hA000_0003);
      give_word(32'hA000_0003);
      @(negedge clk);
      chk("full_count", 32'(count), 32'd4);
      chk("full_head_pc", pc_o, 32'h10C);
      busy = 1'b0;
      n_en = 0;
      repeat (5) begin
         @(negedge clk);
         if (fetch_en) n_en++;
      end
      chk("full_no_req", 32'(n_en), 32'd0);
      chk("full_head_hold", pc_o, 32'h10C);

      // One pop frees one slot -> exactly one new request
      tick();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      wait_req(32'h11C, "refill");
      expect_pop(32'h11C, 32'hA000_0004);
      give_word(32'hA000_0004);
      busy = 1'b0;
      n_en = 0;
      repeat (5) begin
         @(negedge clk);
         if (fetch_en) n_en++;
      end
      chk("refill_single_req", 32'(n_en), 32'd0);
      chk("refill_count", 32'(count), 32'd4);
      tick();
      busy  = 1'b1;
      ready = 1'b1;
      drain("full_drain_count");

      // Flush while a fetch is outstanding; the stale word must vanish
      wait_req(32'h120, "pre_flush");
      flush    = 1'b1;
      redirect = 32'h0000_2002;
      @(negedge clk);
      chk("flush_no_req", 32'(fetch_en), 32'd0);
      tick();
      flush     = 1'b0;
      busy      = 1'b0;
      new_instr = 1'b1;
      instr     = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("discard_no_req", 32'(fetch_en), 32'd0);
      tick();
      new_instr = 1'b0;
      busy      = 1'b1;
      @(negedge clk);
      chk("discard_count", 32'(count), 32'd0);
      chk("discard_valid", 32'(valid), 32'd0);
      tick();
      wait_req(32'h2000, "redirect");
      expect_pop(32'h2000, 32'h1111_1111);
      give_word(32'h1111_1111);
      drain("redirect_drain");

      // Push and pop in the same cycle at count=2
      ready = 1'b0;
      wait_req(32'h2004, "pp0");
      expect_pop(32'h2004, 32'hC000_0004);
      give_word(32'hC000_0004);
      wait_req(32'h2008, "pp1");
      expect_pop(32'h2008, 32'hC000_0008);
      give_word(32'hC000_0008);
      wait_req(32'h200C, "pp2");
      expect_pop(32'h200C, 32'hC000_000C);
      new_instr = 1'b1;
      instr     = 32'hC000_000C;
      ready     = 1'b1;
      @(negedge clk);
      chk("pp_count_before", 32'(count), 32'd2);
      tick();
      new_instr = 1'b0;
      ready     = 1'b0;
      @(negedge clk);
      chk("pp_count_after", 32'(count), 32'd2);
      chk("pp_head_pc", pc_o, 32'h2008);
      chk("pp_head_instr", instr_o, 32'hC000_0008);
      tick();
      @(negedge clk);
      chk("pp_head_hold", pc_o, 32'h2008);
      tick();
      ready = 1'b1;
      drain("pp_drain");

      // Return latency into an empty FIFO with a ready consumer
      wait_req(32'h2010, "lat");
      expect_pop(32'h2010, 32'hDEAD_BEEF);
      new_instr = 1'b1;
      instr     = 32'hDEAD_BEEF;
      @(negedge clk);
`ifdef RISTRETTO_PFB_BYPASS_EN
      chk("byp_valid", 32'(valid), 32'd1);
      chk("byp_instr", instr_o, 32'hDEAD_BEEF);
      chk("byp_pc", pc_o, 32'h2010);
      tick();
      new_instr = 1'b0;
      @(negedge clk);
      chk("byp_count", 32'(count), 32'd0);
      chk("byp_valid_after", 32'(valid), 32'd0);
      tick();
`else
      chk("lat_valid_same", 32'(valid), 32'd0);
      tick();
      new_instr = 1'b0;
      @(negedge clk);
      chk("lat_valid_next", 32'(valid), 32'd1);
      chk("lat_instr_next", instr_o, 32'hDEAD_BEEF);
      chk("lat_count_next", 32'(count), 32'd1);
      tick();
`endif

      // Redirect near the top of the address space and wrap
      flush    = 1'b1;
      redirect = 32'hFFFF_FFFF;
      tick();
      flush = 1'b0;
      wait_req(32'hFFFF_FFFC, "wrap0");
      expect_pop(32'hFFFF_FFFC, 32'h2222_2222);
      give_word(32'h2222_2222);
      wait_req(32'h0000_0000, "wrap1");
      expect_pop(32'h0000_0000, 32'h3333_3333);
      give_word(32'h3333_3333);
      drain("wrap_drain");
      repeat (2) tick();
      chk("sb_drained", 32'(exp_pc_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
